mode_sequencer: RTL and testbench
=================================

// Module: mode_sequencer
// PURPOSE
//  Front-end controller for the counter/LRU-buffer datapath. Synchronises and
//  debounces the three board buttons (mode, clear, set). Sequences the one-hot
//  datapath mode CNT_EN -> LRU_WR -> LRU_RD -> CNT_EN on each mode press.
//  Drives the datapath's state/rst/set inputs with clean, glitch-free levels.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable cycles before a button level is accepted (>=2)
//  CNT_W            $clog2(DEBOUNCE_CYCLES)+1  debounce counter width (derived, not overridden)
// PORTS
//  clk_i        in   1  system clock, all logic on posedge
//  rst_i        in   1  asynchronous active-high reset
//  btn_mode_i   in   1  raw mode button, asynchronous, active-high
//  btn_clr_i    in   1  raw clear button, asynchronous, active-high
//  btn_set_i    in   1  raw set button, asynchronous, active-high
//  state_o      out  3  one-hot mode: 100=CNT_EN, 010=LRU_WR, 001=LRU_RD
//  clr_o        out  1  debounced clear level, masked (see BEHAVIOUR)
//  set_o        out  1  debounced set level, masked (see BEHAVIOUR)
//  mode_chg_o   out  1  1-cycle pulse in the first cycle state_o shows a new mode
//  pending_o    out  1  mode advance requested but held off
// BEHAVIOUR
//  Reset (async assert, sync release via registers): state_o=100, clr_o=0, set_o=0,
//   mode_chg_o=0, pending_o=0; all sync FFs, debounced levels and counters = 0.
//  Per button: 2-FF synchroniser -> sync level s.
//   Debounced level d, counter c:
//   - s==d: c<=0.
//   - s!=d and c<DEBOUNCE_CYCLES-1: c<=c+1.
//   - s!=d and c==DEBOUNCE_CYCLES-1: d<=s, c<=0.
//   - A bounce (s returns to d) before the limit restarts the count.
//   - Latency from a stable raw edge to d change: exactly 2+DEBOUNCE_CYCLES cycles.
//   - rise = d & ~d_q, a 1-cycle pulse.
//  Mode FSM states:
//   - RUN: on mode rise with clr_d=0 and set_d=0, advance next edge.
//   - RUN: on mode rise with clr_d=1 or set_d=1, go to HOLD, pending_o=1.
//   - HOLD: stay while clr_d|set_d. When both are 0, advance and return to RUN.
//   - HOLD: further mode rises are ignored; one advance per HOLD entry.
//   - Advance order: 100->010->001->100 (wrap). mode_chg_o=1 in the cycle after the state register updates.
//   - Any illegal state_o value (not one-hot) recovers to 100 on the next edge.
//  Output masking:
//   - clr_o=clr_d and set_o=set_d only when the FSM is in RUN and mode_chg_o=0.
//   - Otherwise both are 0, so a mode switch never produces a spurious set edge
//     or clear in the new mode.
//   - Masked levels are registered: clr_o/set_o lag clr_d/set_d by 1 cycle.
//  Simultaneous events:
//   - A mode rise in the same cycle as a set/clr rise counts as busy: go to HOLD.
//   - rst_i mid-debounce or mid-HOLD aborts immediately to reset values.
// STRUCTURE
//  Shared header mode_defs.vh:
//   - MODE_CNT_EN=3'b100, MODE_LRU_WR=3'b010, MODE_LRU_RD=3'b001.
//   - The datapath uses the same constants.
//  Sub-module btn_debounce:
//   - Ports: clk_i, rst_i, raw_i, level_o, rise_o; parameter DEBOUNCE_CYCLES.
//   - Instantiated 3x.
//  Top level: FSM (RUN/HOLD), mode register, masking registers.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Reset -> state_o=100, clr_o=set_o=mode_chg_o=pending_o=0, held through release.
//  2. btn_mode clean high 20 cycles -> state_o=010 at cycle 2+4+1.
//     mode_chg_o high for exactly 1 cycle. Three more presses -> 001, 100, 010.
//  3. btn_set bounce 1,0,1,0 (1 cycle each) then high -> set_o rises only after
//     4 stable sync cycles (+1 reg). No glitch pulses on set_o.
//  4. Hold btn_set, press mode -> pending_o=1, state_o unchanged, set_o=0.
//     Release set -> state advances once after set_d falls. set_o stays 0 throughout.
//  5. Assert rst_i during HOLD and mid-debounce count -> outputs reset same cycle.
//     After release, a 3-cycle pulse is rejected; a 6-cycle pulse is accepted.
//  6. Force the state register to 3'b011 -> recovers to 100 next edge, mode_chg_o=1.

Source files
------------

// File: rtl/mode_sequencer_pkg.sv
// Shared definitions for the mode sequencer and the counter/LRU datapath.
// Contents:
//   MODE_*        one-hot datapath mode encodings (same constants as the datapath)
//   fsm_state_t   front-end controller states (RUN / HOLD)
//   is_one_hot    legality check for a mode value
//   next_mode     advance order CNT_EN -> LRU_WR -> LRU_RD -> CNT_EN
package mode_sequencer_pkg;

    localparam logic [2:0] MODE_CNT_EN = 3'b100;
    localparam logic [2:0] MODE_LRU_WR = 3'b010;
    localparam logic [2:0] MODE_LRU_RD = 3'b001;

    typedef enum logic {
        FSM_RUN  = 1'b0,
        FSM_HOLD = 1'b1
    } fsm_state_t;

    function automatic logic is_one_hot(input logic [2:0] mode);
        return (mode == MODE_CNT_EN) || (mode == MODE_LRU_WR) || (mode == MODE_LRU_RD);
    endfunction

    // Illegal inputs map to CNT_EN so the caller always gets a legal mode.
    function automatic logic [2:0] next_mode(input logic [2:0] mode);
        logic [2:0] nxt;
        case (mode)
            MODE_CNT_EN: nxt = MODE_LRU_WR;
            MODE_LRU_WR: nxt = MODE_LRU_RD;
            MODE_LRU_RD: nxt = MODE_CNT_EN;
            default:     nxt = MODE_CNT_EN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mode_sequencer_debounce.sv
// Button conditioner: 2-FF synchroniser followed by a stable-count debouncer.
// The debounced level changes only after the synchronised input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles; any return to the current
// level restarts the count. Raw edge to level change is 2+DEBOUNCE_CYCLES cycles.
// Ports:
//   clk_i    in   system clock
//   rst_i    in   asynchronous active-high reset
//   raw_i    in   raw asynchronous button
//   level_o  out  debounced level (registered)
//   rise_o   out  1-cycle pulse in the first cycle level_o is high
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_q_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchroniser, stable-count debouncer and previous-level register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            level_q_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            sync1_r   <= raw_i;
            sync2_r   <= sync1_r;
            level_q_r <= level_r;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LIMIT) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign level_o = level_r;
    assign rise_o  = level_r & ~level_q_r;

endmodule

// File: rtl/mode_sequencer.sv
// Front-end controller for the counter/LRU-buffer datapath.
// Debounces the mode/clear/set buttons, sequences the one-hot datapath mode on
// each mode press and drives clean clear/set levels that are suppressed while a
// mode change is pending or has just happened.
// Ports:
//   clk_i       in   system clock
//   rst_i       in   asynchronous active-high reset
//   btn_mode_i  in   raw mode button
//   btn_clr_i   in   raw clear button
//   btn_set_i   in   raw set button
//   state_o     out  one-hot mode 100=CNT_EN, 010=LRU_WR, 001=LRU_RD
//   clr_o       out  masked debounced clear level
//   set_o       out  masked debounced set level
//   mode_chg_o  out  1-cycle pulse in the first cycle state_o shows a new mode
//   pending_o   out  mode advance requested but held off by clear/set
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_mode_i,
    input  logic       btn_clr_i,
    input  logic       btn_set_i,
    output logic [2:0] state_o,
    output logic       clr_o,
    output logic       set_o,
    output logic       mode_chg_o,
    output logic       pending_o
);

    logic       mode_rise_s;
    logic       clr_d_s;
    logic       set_d_s;
    logic       busy_s;
    fsm_state_t fsm_r;
    logic [2:0] mode_r;
    logic       mode_chg_r;
    logic       pending_r;
    logic       clr_r;
    logic       set_r;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .raw_i   (btn_mode_i),
        .level_o (),
        .rise_o  (mode_rise_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .raw_i   (btn_clr_i),
        .level_o (clr_d_s),
        .rise_o  ()
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .raw_i   (btn_set_i),
        .level_o (set_d_s),
        .rise_o  ()
    );

    // A held clear or set blocks the mode switch so the datapath never sees a
    // clear/set level straddle two modes.
    assign busy_s = clr_d_s | set_d_s;

    // Mode FSM, mode register and masked clear/set output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_r      <= FSM_RUN;
            mode_r     <= MODE_CNT_EN;
            mode_chg_r <= 1'b0;
            pending_r  <= 1'b0;
            clr_r      <= 1'b0;
            set_r      <= 1'b0;
        end else begin
            mode_chg_r <= 1'b0;
            // Mask uses the pre-edge FSM state and change pulse, so the levels
            // stay low through HOLD and the first cycle of a new mode.
            if ((fsm_r == FSM_RUN) && !mode_chg_r) begin
                clr_r <= clr_d_s;
                set_r <= set_d_s;
            end else begin
                clr_r <= 1'b0;
                set_r <= 1'b0;
            end

            if (!is_one_hot(mode_r)) begin
                // Corrupted mode register: fall back to the power-on mode.
                mode_r     <= MODE_CNT_EN;
                mode_chg_r <= 1'b1;
                fsm_r      <= FSM_RUN;
                pending_r  <= 1'b0;
            end else begin
                case (fsm_r)
                    FSM_RUN: begin
                        if (mode_rise_s) begin
                            if (busy_s) begin
                                fsm_r     <= FSM_HOLD;
                                pending_r <= 1'b1;
                            end else begin
                                mode_r     <= next_mode(mode_r);
                                mode_chg_r <= 1'b1;
                            end
                        end
                    end
                    FSM_HOLD: begin
                        // Extra mode presses here are dropped: one advance per hold.
                        if (!busy_s) begin
                            mode_r     <= next_mode(mode_r);
                            mode_chg_r <= 1'b1;
                            fsm_r      <= FSM_RUN;
                            pending_r  <= 1'b0;
                        end
                    end
                    default: begin
                        fsm_r     <= FSM_RUN;
                        pending_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_o    = mode_r;
    assign clr_o      = clr_r;
    assign set_o      = set_r;
    assign mode_chg_o = mode_chg_r;
    assign pending_o  = pending_r;

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer with DEBOUNCE_CYCLES=4.
// A behavioural reference model (sample-history debouncing, mode index
// arithmetic) predicts every output each cycle under directed and random stimulus.
module tb_mode_sequencer;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_set = 1'b0;
    logic [2:0] state;
    logic       clr;
    logic       set;
    logic       mode_chg;
    logic       pending;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: buttons indexed 0=mode, 1=clr, 2=set.
    bit raw_q [3][$];
    bit smp_q [3][$];
    bit m_d   [3];
    bit m_dp  [3];
    int e_idx;
    bit e_hold;
    bit e_chg;
    bit e_clr;
    bit e_set;
    bit e_illegal;

    mode_sequencer #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .btn_mode_i (btn_mode),
        .btn_clr_i  (btn_clr),
        .btn_set_i  (btn_set),
        .state_o    (state),
        .clr_o      (clr),
        .set_o      (set),
        .mode_chg_o (mode_chg),
        .pending_o  (pending)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] observed();
        return {1'b0, state, clr, set, mode_chg, pending};
    endfunction

    function automatic logic [7:0] expected();
        logic [2:0] onehot;
        onehot = 3'b100 >> e_idx;
        return {1'b0, onehot, e_clr, e_set, e_chg, e_hold};
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            raw_q[b].delete();
            smp_q[b].delete();
            m_d[b]  = 1'b0;
            m_dp[b] = 1'b0;
        end
        e_idx = 0; e_hold = 1'b0; e_chg = 1'b0;
        e_clr = 1'b0; e_set = 1'b0; e_illegal = 1'b0;
    endtask

    // One rising edge of the reference model; raw is {set, clr, mode}.
    task automatic model_step(input bit [2:0] raw);
        bit rise_m;
        bit busy;
        bit new_chg;
        bit all_diff;
        bit s;
        rise_m = m_d[0] & ~m_dp[0];
        busy   = m_d[1] | m_d[2];
        e_clr  = (!e_hold && !e_chg) ? m_d[1] : 1'b0;
        e_set  = (!e_hold && !e_chg) ? m_d[2] : 1'b0;
        new_chg = 1'b0;
        if (e_illegal) begin
            e_idx = 0; new_chg = 1'b1; e_hold = 1'b0; e_illegal = 1'b0;
        end else if (!e_hold) begin
            if (rise_m) begin
                if (busy) e_hold = 1'b1;
                else begin e_idx = (e_idx + 1) % 3; new_chg = 1'b1; end
            end
        end else if (!busy) begin
            e_idx = (e_idx + 1) % 3; new_chg = 1'b1; e_hold = 1'b0;
        end
        e_chg = new_chg;
        // The level seen at this edge is the raw value two edges back; it flips
        // once the last DC seen samples all disagree with it.
        for (int b = 0; b < 3; b++) begin
            raw_q[b].push_back(raw[b]);
            s = (raw_q[b].size() >= 3) ? raw_q[b][raw_q[b].size() - 3] : 1'b0;
            if (raw_q[b].size() > 3) void'(raw_q[b].pop_front());
            smp_q[b].push_back(s);
            if (smp_q[b].size() > DC) void'(smp_q[b].pop_front());
            all_diff = (smp_q[b].size() == DC);
            for (int i = 0; i < smp_q[b].size(); i++)
                if (smp_q[b][i] == m_d[b]) all_diff = 1'b0;
            m_dp[b] = m_d[b];
            if (all_diff) m_d[b] = ~m_d[b];
        end
    endtask

    // Called at a negedge: apply buttons, clock once, compare at the next negedge.
    task automatic cycle(input bit mode_b, input bit clr_b, input bit set_b);
        btn_mode = mode_b; btn_clr = clr_b; btn_set = set_b;
        @(posedge clk);
        if (!rst) model_step({set_b, clr_b, mode_b});
        @(negedge clk);
        check_val("cycle", observed(), expected());
    endtask

    task automatic run(input int n, input bit mode_b, input bit clr_b, input bit set_b);
        for (int i = 0; i < n; i++) cycle(mode_b, clr_b, set_b);
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_val("reset_async", observed(), {1'b0, 3'b100, 4'b0000});
        run(2, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        bit [2:0] rb;
        model_reset();
        @(negedge clk);
        check_val("reset", observed(), {1'b0, 3'b100, 4'b0000});
        run(3, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        run(2, 1'b0, 1'b0, 1'b0);
        check_val("reset_release", observed(), {1'b0, 3'b100, 4'b0000});

        // Clean mode press: state advances on the 7th edge after the raw edge.
        run(6, 1'b1, 1'b0, 1'b0);
        check_val("press_wait", observed(), {1'b0, 3'b100, 4'b0000});
        cycle(1'b1, 1'b0, 1'b0);
        check_val("first_press", observed(), {1'b0, 3'b010, 4'b0010});
        cycle(1'b1, 1'b0, 1'b0);
        check_val("chg_one_cycle", observed(), {1'b0, 3'b010, 4'b0000});
        run(12, 1'b1, 1'b0, 1'b0);
        run(12, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            run(12, 1'b1, 1'b0, 1'b0);
            run(12, 1'b0, 1'b0, 1'b0);
        end
        check_val("three_presses", observed(), {1'b0, 3'b010, 4'b0000});

        // Bouncing set then stable high.
        run(1, 1'b0, 1'b0, 1'b1); run(1, 1'b0, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b1); run(1, 1'b0, 1'b0, 1'b0);
        run(15, 1'b0, 1'b0, 1'b1);
        check_val("set_level", observed(), {1'b0, 3'b010, 4'b0100});

        // Mode press while set held: hold off, then advance once on release.
        run(12, 1'b1, 1'b0, 1'b1);
        check_val("hold_pending", observed(), {1'b0, 3'b010, 4'b0001});
        run(8, 1'b0, 1'b0, 1'b1);
        run(12, 1'b1, 1'b0, 1'b1);
        run(20, 1'b0, 1'b0, 1'b0);
        check_val("hold_release", observed(), {1'b0, 3'b001, 4'b0000});

        // Reset in the middle of HOLD and mid-debounce.
        run(12, 1'b0, 1'b1, 1'b0);
        run(10, 1'b1, 1'b1, 1'b0);
        run(2, 1'b0, 1'b1, 1'b1);
        async_reset();
        run(3, 1'b1, 1'b0, 1'b0);
        run(12, 1'b0, 1'b0, 1'b0);
        check_val("short_pulse", observed(), {1'b0, 3'b100, 4'b0000});
        run(6, 1'b1, 1'b0, 1'b0);
        run(12, 1'b0, 1'b0, 1'b0);
        check_val("long_pulse", observed(), {1'b0, 3'b010, 4'b0000});

        // Corrupt the mode register; it must recover on the next edge.
        force dut.mode_r = 3'b011;
        #1;
        release dut.mode_r;
        e_illegal = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        check_val("illegal_recover", observed(), {1'b0, 3'b100, 4'b0010});

        // Random button activity with occasional resets.
        rb = 3'b000;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 5) == 0) rb[b] = ~rb[b];
            if ($urandom_range(0, 299) == 0) async_reset();
            cycle(rb[0], rb[1], rb[2]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
